// File: rtl/mem_stage_nway.sv
// mem_stage_nway: N-lane memory-access stage between EX and WB.
// Holds one issue bundle and performs its data-memory accesses one at a time,
// in lane order, over a req/addr_ok/data_ok interface. Aligns load data,
// applies the precise exception kill mask and drives per-lane writeback.
module mem_stage_nway #(
    parameter int LANES = 2,
    parameter int AW    = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  flush,
    input  logic                  stall_in,
    input  logic [LANES-1:0]      in_valid,
    input  logic [LANES-1:0]      in_mem_en,
    input  logic [LANES-1:0]      in_mem_we,
    input  logic [3*LANES-1:0]    in_mem_op,
    input  logic [AW*LANES-1:0]   in_addr,
    input  logic [32*LANES-1:0]   in_wdata,
    input  logic [LANES-1:0]      in_rf_we,
    input  logic [5*LANES-1:0]    in_rf_waddr,
    input  logic [32*LANES-1:0]   in_ex_result,
    input  logic [LANES-1:0]      in_exc,
    output logic                  data_req,
    output logic                  data_wr,
    output logic [1:0]            data_size,
    output logic [AW-1:0]         data_addr,
    output logic [31:0]           data_wdata,
    output logic [3:0]            data_wstrb,
    input  logic                  data_addr_ok,
    input  logic                  data_data_ok,
    input  logic [31:0]           data_rdata,
    output logic                  stall_req,
    output logic                  exc_valid,
    output logic [1:0]            exc_lane,
    output logic [LANES-1:0]      wb_valid,
    output logic [LANES-1:0]      wb_we,
    output logic [5*LANES-1:0]    wb_waddr,
    output logic [32*LANES-1:0]   wb_wdata
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    // Byte enables for a store of the given size at byte offset a.
    function automatic logic [3:0] store_strb(input logic [1:0] size, input logic [1:0] a);
        case (size)
            2'd0:    return 4'b0001 << a;
            2'd1:    return 4'b0011 << a;
            default: return 4'b1111;
        endcase
    endfunction

    // Store data replicated across the bus so any byte lane picks it up.
    function automatic logic [31:0] store_data(input logic [1:0] size, input logic [31:0] wd);
        case (size)
            2'd0:    return {4{wd[7:0]}};
            2'd1:    return {2{wd[15:0]}};
            default: return wd;
        endcase
    endfunction

    // Select the addressed byte/half from the read word and extend it.
    function automatic logic [31:0] load_align(input logic [2:0] op, input logic [1:0] a,
                                               input logic [31:0] rd);
        logic signed [7:0]  lb;
        logic signed [15:0] lh;
        lb = rd[{a, 3'b000} +: 8];
        lh = a[1] ? rd[31:16] : rd[15:0];
        case (op[1:0])
            2'd0:    return op[2] ? {{24{lb[7]}}, lb} : {24'd0, lb};
            2'd1:    return op[2] ? {{16{lh[15]}}, lh} : {16'd0, lh};
            default: return rd;
        endcase
    endfunction

    // Stage register (p0)
    logic [LANES-1:0]    vld_p0, mem_en_p0, mem_we_p0, rf_we_p0, exc_p0;
    logic [3*LANES-1:0]  mem_op_p0;
    logic [AW*LANES-1:0] addr_p0;
    logic [32*LANES-1:0] wdata_p0, ex_result_p0, ld_data_p0;
    logic [5*LANES-1:0]  rf_waddr_p0;

    logic [1:0]       state, state_nxt;
    logic [1:0]       cur, cur_nxt;
    logic             done;
    logic             done_set, capture, load_en;
    logic [LANES-1:0] kill, acc;
    logic             exc_found;
    logic [1:0]       exc_k;
    logic [1:0]       first_lane, next_lane;
    logic             has_next, any_acc;
    logic             sel_we;
    logic [2:0]       sel_op;
    logic [AW-1:0]    sel_addr;
    logic [31:0]      sel_wdata;

    assign load_en = ~stall_req & ~stall_in;

    // Lane valids: the only stage-register state that needs reset/flush.
    always_ff @(posedge clk) begin
        if (rst || flush)
            vld_p0 <= '0;
        else if (load_en)
            vld_p0 <= in_valid;
    end

    // Stage register payload follows the valid load enable.
    always_ff @(posedge clk) begin
        if (load_en) begin
            mem_en_p0    <= in_mem_en;
            mem_we_p0    <= in_mem_we;
            mem_op_p0    <= in_mem_op;
            addr_p0      <= in_addr;
            wdata_p0     <= in_wdata;
            rf_we_p0     <= in_rf_we;
            rf_waddr_p0  <= in_rf_waddr;
            ex_result_p0 <= in_ex_result;
            exc_p0       <= in_exc;
        end
    end

    // Kill mask: everything from the lowest excepting lane upward.
    always_comb begin
        exc_found = 1'b0;
        exc_k     = 2'd0;
        kill      = '0;
        for (int i = 0; i < LANES; i++) begin
            if (!exc_found && vld_p0[i] && exc_p0[i]) begin
                exc_found = 1'b1;
                exc_k     = 2'(i);
            end
            kill[i] = exc_found;
        end
    end

    assign acc     = vld_p0 & mem_en_p0 & ~kill;
    assign any_acc = |acc;

    // First access lane and the next one after cur (descending scan keeps the lowest).
    always_comb begin
        first_lane = 2'd0;
        next_lane  = 2'd0;
        has_next   = 1'b0;
        for (int i = LANES - 1; i >= 0; i--) begin
            if (acc[i])
                first_lane = 2'(i);
            if (acc[i] && (2'(i) > cur)) begin
                next_lane = 2'(i);
                has_next  = 1'b1;
            end
        end
    end

    // Fields of the lane currently being served.
    always_comb begin
        sel_we    = 1'b0;
        sel_op    = 3'd0;
        sel_addr  = '0;
        sel_wdata = 32'd0;
        for (int i = 0; i < LANES; i++) begin
            if (cur == 2'(i)) begin
                sel_we    = mem_we_p0[i];
                sel_op    = mem_op_p0[i*3 +: 3];
                sel_addr  = addr_p0[i*AW +: AW];
                sel_wdata = wdata_p0[i*32 +: 32];
            end
        end
    end

    // Access sequencer next state; only one access is ever outstanding.
    always_comb begin
        state_nxt = state;
        cur_nxt   = cur;
        capture   = 1'b0;
        done_set  = 1'b0;
        case (state)
            S_IDLE: begin
                if (!flush && any_acc && !done) begin
                    state_nxt = S_REQ;
                    cur_nxt   = first_lane;
                end
            end
            S_REQ: begin
                // A flush that coincides with acceptance still owes us a response.
                if (flush)
                    state_nxt = data_addr_ok ? S_DRAIN : S_IDLE;
                else if (data_addr_ok)
                    state_nxt = S_WAIT;
            end
            S_WAIT: begin
                if (flush) begin
                    state_nxt = data_data_ok ? S_IDLE : S_DRAIN;
                end else if (data_data_ok) begin
                    capture = 1'b1;
                    if (has_next) begin
                        state_nxt = S_REQ;
                        cur_nxt   = next_lane;
                    end else begin
                        state_nxt = S_IDLE;
                        done_set  = 1'b1;
                    end
                end
            end
            default: begin
                if (data_data_ok)
                    state_nxt = S_IDLE;
            end
        endcase
    end

    // Sequencer state and lane pointer.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IDLE;
            cur   <= 2'd0;
        end else begin
            state <= state_nxt;
            cur   <= cur_nxt;
        end
    end

    // Bundle-done flag: set by the last response, cleared when a new bundle loads.
    always_ff @(posedge clk) begin
        if (rst || flush)
            done <= 1'b0;
        else if (load_en)
            done <= 1'b0;
        else if (done_set)
            done <= 1'b1;
    end

    // Aligned load data captured into the served lane's slot.
    always_ff @(posedge clk) begin
        if (capture) begin
            for (int i = 0; i < LANES; i++) begin
                if (cur == 2'(i))
                    ld_data_p0[i*32 +: 32] <= load_align(sel_op, sel_addr[1:0], data_rdata);
            end
        end
    end

    assign stall_req  = (any_acc & ~done) | (state == S_DRAIN);
    assign exc_valid  = exc_found;
    assign exc_lane   = exc_k;

    assign data_req   = (state == S_REQ);
    assign data_wr    = data_req & sel_we;
    assign data_size  = data_req ? sel_op[1:0] : 2'd0;
    assign data_addr  = data_req ? sel_addr : '0;
    assign data_wdata = data_req ? store_data(sel_op[1:0], sel_wdata) : 32'd0;
    assign data_wstrb = (data_req & sel_we) ? store_strb(sel_op[1:0], sel_addr[1:0]) : 4'd0;

    assign wb_valid = vld_p0 & ~kill & {LANES{~stall_req}};
    assign wb_we    = wb_valid & rf_we_p0;

    // Writeback payload, zeroed on lanes that do not commit.
    always_comb begin
        wb_waddr = '0;
        wb_wdata = '0;
        for (int i = 0; i < LANES; i++) begin
            if (wb_valid[i]) begin
                wb_waddr[i*5 +: 5]  = rf_waddr_p0[i*5 +: 5];
                wb_wdata[i*32 +: 32] = (mem_en_p0[i] && !mem_we_p0[i]) ?
                                       ld_data_p0[i*32 +: 32] : ex_result_p0[i*32 +: 32];
            end
        end
    end

endmodule

// File: tb/tb_mem_stage_nway.sv
// Directed testbench for mem_stage_nway with LANES=2.
module tb_mem_stage_nway;

    logic        clk = 1'b0;
    logic        rst, flush, stall_in;
    logic [1:0]  in_valid, in_mem_en, in_mem_we, in_rf_we, in_exc;
    logic [5:0]  in_mem_op;
    logic [63:0] in_addr, in_wdata, in_ex_result;
    logic [9:0]  in_rf_waddr;
    logic        data_req, data_wr;
    logic [1:0]  data_size;
    logic [31:0] data_addr, data_wdata;
    logic [3:0]  data_wstrb;
    logic        data_addr_ok, data_data_ok;
    logic [31:0] data_rdata;
    logic        stall_req, exc_valid;
    logic [1:0]  exc_lane;
    logic [1:0]  wb_valid, wb_we;
    logic [9:0]  wb_waddr;
    logic [63:0] wb_wdata;

    int checks = 0;
    int failures = 0;

    mem_stage_nway #(.LANES(2), .AW(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .stall_in(stall_in),
        .in_valid(in_valid), .in_mem_en(in_mem_en), .in_mem_we(in_mem_we),
        .in_mem_op(in_mem_op), .in_addr(in_addr), .in_wdata(in_wdata),
        .in_rf_we(in_rf_we), .in_rf_waddr(in_rf_waddr), .in_ex_result(in_ex_result),
        .in_exc(in_exc),
        .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
        .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
        .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
        .stall_req(stall_req), .exc_valid(exc_valid), .exc_lane(exc_lane),
        .wb_valid(wb_valid), .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_in();
        in_valid = '0; in_mem_en = '0; in_mem_we = '0; in_mem_op = '0;
        in_addr = '0; in_wdata = '0; in_rf_we = '0; in_rf_waddr = '0;
        in_ex_result = '0; in_exc = '0;
    endtask

    task automatic set_lane(input int l, input logic men, input logic we, input logic [2:0] op,
                            input logic [31:0] addr, input logic [31:0] wd, input logic rfwe,
                            input logic [4:0] wa, input logic [31:0] ex, input logic exc);
        in_valid[l]             = 1'b1;
        in_mem_en[l]            = men;
        in_mem_we[l]            = we;
        in_mem_op[l*3 +: 3]     = op;
        in_addr[l*32 +: 32]     = addr;
        in_wdata[l*32 +: 32]    = wd;
        in_rf_we[l]             = rfwe;
        in_rf_waddr[l*5 +: 5]   = wa;
        in_ex_result[l*32 +: 32] = ex;
        in_exc[l]               = exc;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; stall_in = 1'b0;
        data_addr_ok = 1'b0; data_data_ok = 1'b0; data_rdata = 32'd0;
        clr_in();
        tick(); tick();
        chk("rst_data_req", 64'(data_req), 64'(0));
        chk("rst_stall_req", 64'(stall_req), 64'(0));
        chk("rst_exc_valid", 64'(exc_valid), 64'(0));
        chk("rst_exc_lane", 64'(exc_lane), 64'(0));
        chk("rst_wb_valid", 64'(wb_valid), 64'(0));
        chk("rst_wb_we", 64'(wb_we), 64'(0));
        chk("rst_wb_wdata", wb_wdata, 64'(0));
        chk("rst_data_addr", 64'(data_addr), 64'(0));
        rst = 1'b0;

        // lb at 0x1003 in lane0, ALU in lane1
        set_lane(0, 1'b1, 1'b0, 3'b100, 32'h1003, 32'h0, 1'b1, 5'd3, 32'h1003, 1'b0);
        set_lane(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 5'd4, 32'd5, 1'b0);
        tick(); clr_in();
        chk("lb_stall_idle", 64'(stall_req), 64'(1));
        chk("lb_wbv_idle", 64'(wb_valid), 64'(0));
        tick();
        chk("lb_req", 64'(data_req), 64'(1));
        chk("lb_wr", 64'(data_wr), 64'(0));
        chk("lb_size", 64'(data_size), 64'(0));
        chk("lb_addr", 64'(data_addr), 64'h1003);
        chk("lb_wstrb", 64'(data_wstrb), 64'(0));
        data_addr_ok = 1'b1; tick(); data_addr_ok = 1'b0;
        chk("lb_wait_req", 64'(data_req), 64'(0));
        chk("lb_wait_stall", 64'(stall_req), 64'(1));
        data_data_ok = 1'b1; data_rdata = 32'h80FF_0000; tick(); data_data_ok = 1'b0;
        chk("lb_stall_done", 64'(stall_req), 64'(0));
        chk("lb_wb_valid", 64'(wb_valid), 64'(2'b11));
        chk("lb_wb_we", 64'(wb_we), 64'(2'b11));
        chk("lb_wb_wdata", wb_wdata, 64'h0000_0005_FFFF_FF80);
        chk("lb_wb_waddr", 64'(wb_waddr), 64'({5'd4, 5'd3}));
        tick();
        chk("lb_after_wbv", 64'(wb_valid), 64'(0));

        // sh 0x2002 then sw 0x2004
        set_lane(0, 1'b1, 1'b1, 3'b001, 32'h2002, 32'h0000_1234, 1'b0, 5'd0, 32'h0, 1'b0);
        set_lane(1, 1'b1, 1'b1, 3'b010, 32'h2004, 32'hCAFE_BABE, 1'b0, 5'd0, 32'h0, 1'b0);
        tick(); clr_in(); tick();
        chk("sh_wr", 64'(data_wr), 64'(1));
        chk("sh_size", 64'(data_size), 64'(1));
        chk("sh_addr", 64'(data_addr), 64'h2002);
        chk("sh_wstrb", 64'(data_wstrb), 64'(4'b1100));
        chk("sh_wdata", 64'(data_wdata), 64'h1234_1234);
        data_addr_ok = 1'b1; tick(); data_addr_ok = 1'b0;
        data_data_ok = 1'b1; tick(); data_data_ok = 1'b0;
        chk("sw_req", 64'(data_req), 64'(1));
        chk("sw_addr", 64'(data_addr), 64'h2004);
        chk("sw_wstrb", 64'(data_wstrb), 64'hF);
        chk("sw_wdata", 64'(data_wdata), 64'hCAFE_BABE);
        chk("sw_size", 64'(data_size), 64'(2));
        data_addr_ok = 1'b1; tick(); data_addr_ok = 1'b0;
        data_data_ok = 1'b1; tick(); data_data_ok = 1'b0;
        chk("st_stall_done", 64'(stall_req), 64'(0));
        chk("st_wb_valid", 64'(wb_valid), 64'(2'b11));
        chk("st_wb_we", 64'(wb_we), 64'(0));
        tick();

        // exception on lane0 kills the lane1 load
        set_lane(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 5'd1, 32'h11, 1'b1);
        set_lane(1, 1'b1, 1'b0, 3'b010, 32'h3000, 32'h0, 1'b1, 5'd2, 32'h0, 1'b0);
        tick();
        clr_in();
        set_lane(0, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 5'd6, 32'h77, 1'b0);
        set_lane(1, 1'b1, 1'b0, 3'b010, 32'h3000, 32'h0, 1'b1, 5'd2, 32'h0, 1'b1);
        chk("exc0_valid", 64'(exc_valid), 64'(1));
        chk("exc0_lane", 64'(exc_lane), 64'(0));
        chk("exc0_wbv", 64'(wb_valid), 64'(0));
        chk("exc0_stall", 64'(stall_req), 64'(0));
        tick();
        chk("exc1_req", 64'(data_req), 64'(0));
        chk("exc1_valid", 64'(exc_valid), 64'(1));
        chk("exc1_lane", 64'(exc_lane), 64'(1));
        chk("exc1_wbv", 64'(wb_valid), 64'(2'b01));
        chk("exc1_wb_we", 64'(wb_we), 64'(2'b01));
        chk("exc1_wdata", wb_wdata, 64'h0000_0000_0000_0077);
        clr_in(); tick();
        chk("exc_clear", 64'(exc_valid), 64'(0));
        tick();
        chk("exc_no_req", 64'(data_req), 64'(0));

        // flush while the request is still waiting for addr_ok
        set_lane(0, 1'b1, 1'b0, 3'b010, 32'h4000, 32'h0, 1'b1, 5'd8, 32'h0, 1'b0);
        tick(); clr_in(); tick();
        chk("fr_req", 64'(data_req), 64'(1));
        flush = 1'b1; tick(); flush = 1'b0;
        chk("fr_req_dropped", 64'(data_req), 64'(0));
        chk("fr_stall", 64'(stall_req), 64'(0));
        chk("fr_wbv", 64'(wb_valid), 64'(0));

        // flush in WAIT, late response drained
        set_lane(0, 1'b1, 1'b0, 3'b010, 32'h4400, 32'h0, 1'b1, 5'd9, 32'h0, 1'b0);
        tick(); clr_in(); tick();
        data_addr_ok = 1'b1; tick(); data_addr_ok = 1'b0;
        flush = 1'b1; tick(); flush = 1'b0;
        chk("fw_stall", 64'(stall_req), 64'(1));
        chk("fw_req", 64'(data_req), 64'(0));
        chk("fw_wbv", 64'(wb_valid), 64'(0));
        set_lane(0, 1'b1, 1'b0, 3'b010, 32'h5000, 32'h0, 1'b1, 5'd10, 32'h0, 1'b0);
        tick();
        chk("fw_drain_stall1", 64'(stall_req), 64'(1));
        chk("fw_drain_req1", 64'(data_req), 64'(0));
        tick();
        chk("fw_drain_stall2", 64'(stall_req), 64'(1));
        data_data_ok = 1'b1; data_rdata = 32'hDEAD_BEEF; tick(); data_data_ok = 1'b0;
        chk("fw_no_wb", 64'(wb_valid), 64'(0));
        for (int i = 0; i < 4; i++) begin
            if (data_req) break;
            tick();
        end
        chk("fw_next_req", 64'(data_req), 64'(1));
        chk("fw_next_addr", 64'(data_addr), 64'h5000);
        clr_in();
        data_addr_ok = 1'b1; tick(); data_addr_ok = 1'b0;
        data_data_ok = 1'b1; data_rdata = 32'h1122_3344; tick(); data_data_ok = 1'b0;
        chk("fw_next_wbv", 64'(wb_valid), 64'(2'b01));
        chk("fw_next_wdata", wb_wdata, 64'h0000_0000_1122_3344);
        chk("fw_next_waddr", 64'(wb_waddr), 64'(10'd10));
        tick();

        // addr_ok withheld with stall_in toggling; lbu at 0x3001
        set_lane(0, 1'b1, 1'b0, 3'b000, 32'h3001, 32'h0, 1'b1, 5'd7, 32'h0, 1'b0);
        set_lane(1, 1'b0, 1'b0, 3'b000, 32'h0, 32'h0, 1'b1, 5'd11, 32'd9, 1'b0);
        tick();
        set_lane(0, 1'b1, 1'b0, 3'b010, 32'h9999, 32'h0, 1'b1, 5'd12, 32'h0, 1'b0);
        tick();
        for (int i = 0; i < 5; i++) begin
            stall_in = (i % 2 == 0);
            chk("hold_req", 64'(data_req), 64'(1));
            chk("hold_addr", 64'(data_addr), 64'h3001);
            chk("hold_size", 64'(data_size), 64'(0));
            tick();
        end
        stall_in = 1'b0;
        data_addr_ok = 1'b1; tick(); data_addr_ok = 1'b0;
        data_data_ok = 1'b1; data_rdata = 32'h0000_AB00; tick(); data_data_ok = 1'b0;
        chk("lbu_wbv", 64'(wb_valid), 64'(2'b11));
        chk("lbu_wdata", wb_wdata, 64'h0000_0009_0000_00AB);
        chk("lbu_waddr", 64'(wb_waddr), 64'({5'd11, 5'd7}));
        clr_in(); tick();

        // reset while waiting for data_ok
        set_lane(0, 1'b1, 1'b0, 3'b010, 32'h6000, 32'h0, 1'b1, 5'd13, 32'h0, 1'b0);
        tick(); clr_in(); tick();
        data_addr_ok = 1'b1; tick(); data_addr_ok = 1'b0;
        rst = 1'b1; tick(); rst = 1'b0;
        chk("rw_req", 64'(data_req), 64'(0));
        chk("rw_stall", 64'(stall_req), 64'(0));
        chk("rw_wbv", 64'(wb_valid), 64'(0));
        data_data_ok = 1'b1; data_rdata = 32'hFFFF_FFFF; tick(); data_data_ok = 1'b0;
        chk("rw_late_req", 64'(data_req), 64'(0));
        chk("rw_late_stall", 64'(stall_req), 64'(0));
        chk("rw_late_wbv", 64'(wb_valid), 64'(0));
        chk("rw_late_we", 64'(wb_we), 64'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
